// File: rtl/cache_arbiter.sv
// cache_arbiter
// Shares one cache controller between the instruction-fetch port (port 0, read only) and the
// load/store port (port 1: read, write, clear, indirect). One request is captured at a time.
// The arbiter drives the controller's commence/ctrl/indirect inputs, waits for outputReady,
// and returns read data with a one-cycle done pulse to the owning requester.
//
// Ports:
//   clk, rst_n                   clock (rising edge), asynchronous active-low reset
//   i_req0, i_req0_addr          port 0 read request (held until o_done0) and address
//   i_req1, i_req1_op            port 1 request (held until o_done1) and op
//                                (10 read, 11 write, 00 clear, 01 illegal)
//   i_req1_indirect              port 1 indirect access flag
//   i_req1_addr, i_req1_wdata    port 1 address and write data
//   i_cache_ready, i_cache_rdata controller outputReady and read data
//   o_commence, o_ctrl           controller run enable (low forces restart) and op code
//   o_indirect                   controller indirect flag
//   o_cache_addr, o_cache_wdata  latched address and write data
//   o_done0, o_done1             one-cycle completion pulses
//   o_rdata                      read data, held until the next completed read
//   o_err                        one-cycle pulse alongside done on timeout or illegal op
//   o_busy                       high whenever the arbiter is not idle
module cache_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned CLR_CYCLES = 3,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req0,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic              i_req1,
    input  logic [1:0]        i_req1_op,
    input  logic              i_req1_indirect,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [DATA_W-1:0] i_req1_wdata,
    input  logic              i_cache_ready,
    input  logic [DATA_W-1:0] i_cache_rdata,
    output logic              o_commence,
    output logic [1:0]        o_ctrl,
    output logic              o_indirect,
    output logic [ADDR_W-1:0] o_cache_addr,
    output logic [DATA_W-1:0] o_cache_wdata,
    output logic              o_done0,
    output logic              o_done1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_err,
    output logic              o_busy
);

    localparam int unsigned CNT_MAX = (TIMEOUT > CLR_CYCLES) ? TIMEOUT : CLR_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_IDLE  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_CLR_LAST = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StRelease} state_t;

    state_t            r_state, w_state_d;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d;
    logic [1:0]        r_op, w_op_d;
    logic              r_owner, r_last_gnt;
    logic              w_grant, w_gnt1, w_owner;
    logic              w_done, w_err_d, w_rdata_we, w_run_d;
    logic              r_commence, r_indirect, r_done0, r_done1, r_err, r_busy;
    logic [1:0]        r_ctrl;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_op_d     = r_op;
        w_grant    = 1'b0;
        w_gnt1     = 1'b0;
        w_done     = 1'b0;
        w_err_d    = 1'b0;
        w_rdata_we = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_req0 || i_req1) begin
                    w_grant = 1'b1;
                    // On a tie, serve the port that was not granted last.
                    w_gnt1  = (i_req0 && i_req1) ? ~r_last_gnt : i_req1;
                    w_op_d  = w_gnt1 ? i_req1_op : OP_READ;
                    if (w_gnt1 && i_req1_op == OP_IDLE) begin
                        // Illegal op: answer immediately, never touch the controller.
                        w_state_d = StRelease;
                        w_done    = 1'b1;
                        w_err_d   = 1'b1;
                    end else begin
                        w_state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                w_cnt_d   = '0;
                w_state_d = StWait;
            end
            StWait: begin
                w_cnt_d = r_cnt + CNT_W'(1);
                // The controller gives no outputReady on clear, so ready is ignored there.
                if (r_op != OP_CLEAR && i_cache_ready) begin
                    w_done     = 1'b1;
                    w_rdata_we = (r_op == OP_READ);
                    w_state_d  = StRelease;
                end else if (r_op == OP_CLEAR && r_cnt == CNT_CLR_LAST) begin
                    w_done    = 1'b1;
                    w_state_d = StRelease;
                end else if (TIMEOUT != 0 && r_cnt == CNT_TIMEOUT) begin
                    w_done    = 1'b1;
                    w_err_d   = 1'b1;
                    w_state_d = StRelease;
                end
            end
            StRelease: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign w_owner = w_grant ? w_gnt1 : r_owner;
    assign w_run_d = (w_state_d == StIssue) || (w_state_d == StWait);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_op       <= OP_IDLE;
            r_owner    <= 1'b0;
            r_last_gnt <= 1'b1;
            r_commence <= 1'b0;
            r_ctrl     <= OP_IDLE;
            r_indirect <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_commence <= w_run_d;
            r_ctrl     <= w_run_d ? w_op_d : OP_IDLE;
            r_done0    <= w_done & ~w_owner;
            r_done1    <= w_done & w_owner;
            r_err      <= w_err_d;
            r_busy     <= (w_state_d != StIdle);
            if (w_grant) begin
                r_op       <= w_op_d;
                r_owner    <= w_gnt1;
                r_last_gnt <= w_gnt1;
                r_addr     <= w_gnt1 ? i_req1_addr : i_req0_addr;
                r_indirect <= w_gnt1 & i_req1_indirect;
                // Port 0 has no write data; keep the previous value.
                if (w_gnt1) begin
                    r_wdata <= i_req1_wdata;
                end
            end
            if (w_rdata_we) begin
                r_rdata <= i_cache_rdata;
            end
        end
    end

    assign o_commence    = r_commence;
    assign o_ctrl        = r_ctrl;
    assign o_indirect    = r_indirect;
    assign o_cache_addr  = r_addr;
    assign o_cache_wdata = r_wdata;
    assign o_done0       = r_done0;
    assign o_done1       = r_done1;
    assign o_rdata       = r_rdata;
    assign o_err         = r_err;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
// Directed bench for cache_arbiter. A transaction-level model (owner, op, age since grant)
// predicts every output each cycle; directed tests add hand-computed literal expectations.
module tb_cache_arbiter;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned CLR_CYCLES = 3;
    localparam int unsigned TIMEOUT    = 255;

    logic              clk;
    logic              rst_n;
    logic              req0;
    logic [ADDR_W-1:0] req0_addr;
    logic              req1;
    logic [1:0]        req1_op;
    logic              req1_indirect;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              cache_ready;
    logic [DATA_W-1:0] cache_rdata;
    logic              commence;
    logic [1:0]        ctrl;
    logic              indirect;
    logic [ADDR_W-1:0] cache_addr;
    logic [DATA_W-1:0] cache_wdata;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    cache_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CLR_CYCLES(CLR_CYCLES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req0         (req0),
        .i_req0_addr    (req0_addr),
        .i_req1         (req1),
        .i_req1_op      (req1_op),
        .i_req1_indirect(req1_indirect),
        .i_req1_addr    (req1_addr),
        .i_req1_wdata   (req1_wdata),
        .i_cache_ready  (cache_ready),
        .i_cache_rdata  (cache_rdata),
        .o_commence     (commence),
        .o_ctrl         (ctrl),
        .o_indirect     (indirect),
        .o_cache_addr   (cache_addr),
        .o_cache_wdata  (cache_wdata),
        .o_done0        (done0),
        .o_done1        (done1),
        .o_rdata        (rdata),
        .o_err          (err),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic              m_active, m_rel, m_owner, m_last, m_ind;
    logic              m_done0, m_done1, m_err, m_fin, m_fin_err;
    logic [1:0]        m_op;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rdata;
    int                m_age, m_idx;
    logic              e_comm;

    always @(posedge clk) begin
        m_done0 = 1'b0;
        m_done1 = 1'b0;
        m_err   = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0; m_rel = 1'b0; m_age = 0; m_last = 1'b1; m_owner = 1'b0;
            m_op = 2'b01; m_ind = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else if (!m_active) begin
            if (req0 || req1) begin
                m_owner  = (req0 && req1) ? !m_last : req1;
                m_last   = m_owner;
                m_active = 1'b1;
                m_rel    = 1'b0;
                m_age    = 0;
                if (m_owner) begin
                    m_op = req1_op; m_ind = req1_indirect;
                    m_addr = req1_addr; m_wdata = req1_wdata;
                end else begin
                    m_op = 2'b10; m_ind = 1'b0; m_addr = req0_addr;
                end
                if (m_owner && m_op == 2'b01) begin
                    m_rel = 1'b1; m_done1 = 1'b1; m_err = 1'b1;
                end
            end
        end else if (m_rel) begin
            m_active = 1'b0;
            m_rel    = 1'b0;
        end else begin
            // Age 0 is the issue cycle; later ages are wait cycles numbered from 0.
            if (m_age >= 1) begin
                m_idx     = m_age - 1;
                m_fin     = 1'b0;
                m_fin_err = 1'b0;
                if (m_op != 2'b00 && cache_ready) begin
                    m_fin = 1'b1;
                    if (m_op == 2'b10) m_rdata = cache_rdata;
                end else if (m_op == 2'b00 && m_idx == int'(CLR_CYCLES) - 1) begin
                    m_fin = 1'b1;
                end else if (TIMEOUT != 0 && m_idx == int'(TIMEOUT)) begin
                    m_fin = 1'b1; m_fin_err = 1'b1;
                end
                if (m_fin) begin
                    m_rel = 1'b1;
                    m_err = m_fin_err;
                    if (m_owner) m_done1 = 1'b1;
                    else m_done0 = 1'b1;
                end
            end
            m_age++;
        end
        e_comm = m_active && !m_rel;
        #1;
        check("commence", commence, e_comm);
        check("ctrl", ctrl, e_comm ? m_op : 2'b01);
        check("indirect", indirect, m_ind);
        check("cache_addr", cache_addr, m_addr);
        check("cache_wdata", cache_wdata, m_wdata);
        check("rdata", rdata, m_rdata);
        check("done0", done0, m_done0);
        check("done1", done1, m_done1);
        check("err", err, m_err);
        check("busy", busy, m_active);
    end

    // ---------------- directed stimulus ----------------
    task automatic run_until_done(input int max_cycles, output int n_comm, output logic got0,
                                  output logic got1, output logic got_err,
                                  output logic [DATA_W-1:0] rd);
        n_comm = 0; got0 = 1'b0; got1 = 1'b0; got_err = 1'b0; rd = '0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done0 || done1) begin
                got0 = done0; got1 = done1; got_err = err; rd = rdata;
                return;
            end
            if (commence) n_comm++;
        end
        checks++;
        failures++;
        $display("FAIL done_bound: no done within %0d cycles at %0t", max_cycles, $time);
    endtask

    task automatic wait_commence(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (commence) return;
        end
        checks++;
        failures++;
        $display("FAIL commence_bound: commence not seen within %0d cycles", max_cycles);
    endtask

    int                n;
    logic              g0, g1, ge;
    logic [DATA_W-1:0] rd;

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req0_addr = '0; req1 = 1'b0; req1_op = 2'b10;
        req1_indirect = 1'b0; req1_addr = '0; req1_wdata = '0;
        cache_ready = 1'b0; cache_rdata = '0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", ctrl, 2'b01);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;

        // 1: reset in the middle of a wait aborts without done
        req0 = 1'b1; req0_addr = 16'h0010;
        wait_commence(5);
        repeat (3) @(negedge clk);
        check("t1_commence_in_wait", commence, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t1_commence_reset", commence, 1'b0);
        check("t1_busy_reset", busy, 1'b0);
        repeat (2) @(negedge clk);
        check("t1_no_done0", done0, 1'b0);
        req0_addr = 16'h0022;
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_regrant_commence", commence, 1'b1);
        check("t1_regrant_addr", cache_addr, 16'h0022);
        cache_ready = 1'b1; cache_rdata = 16'h1111;
        run_until_done(10, n, g0, g1, ge, rd);
        check("t1_done0", g0, 1'b1);
        req0 = 1'b0; cache_ready = 1'b0;
        @(negedge clk);

        // 2: port 0 read, ready during the fourth wait cycle
        req0 = 1'b1; req0_addr = 16'h0040; cache_rdata = 16'hBEEF;
        wait_commence(5);
        check("t2_ctrl_issue", ctrl, 2'b10);
        check("t2_addr", cache_addr, 16'h0040);
        repeat (4) @(negedge clk);
        check("t2_ctrl_wait", ctrl, 2'b10);
        cache_ready = 1'b1;
        run_until_done(10, n, g0, g1, ge, rd);
        check("t2_done0", g0, 1'b1);
        check("t2_rdata", rd, 16'hBEEF);
        check("t2_release_commence", commence, 1'b0);
        req0 = 1'b0; cache_ready = 1'b0;
        @(negedge clk);
        check("t2_done0_one_cycle", done0, 1'b0);
        check("t2_idle", busy, 1'b0);

        // 3: both requests from reset: port 0 first, then the port 1 write
        rst_n = 1'b0;
        req0 = 1'b1; req0_addr = 16'h0050;
        req1 = 1'b1; req1_op = 2'b11; req1_addr = 16'h0080; req1_wdata = 16'h1234;
        cache_ready = 1'b1; cache_rdata = 16'h5A5A;
        @(negedge clk);
        rst_n = 1'b1;
        run_until_done(10, n, g0, g1, ge, rd);
        check("t3_first_is_port0", {g1, g0}, 2'b01);
        check("t3_rdata0", rd, 16'h5A5A);
        req0 = 1'b0;
        wait_commence(5);
        check("t3_wdata", cache_wdata, 16'h1234);
        check("t3_ctrl_write", ctrl, 2'b11);
        check("t3_addr", cache_addr, 16'h0080);
        cache_rdata = 16'hDEAD;
        run_until_done(10, n, g0, g1, ge, rd);
        check("t3_done1", g1, 1'b1);
        check("t3_rdata_unchanged", rd, 16'h5A5A);
        req1 = 1'b0; cache_ready = 1'b0;
        @(negedge clk);

        // 4: clear holds commence for the issue cycle plus three wait cycles
        req1 = 1'b1; req1_op = 2'b00; req1_addr = 16'h0003; req1_indirect = 1'b1;
        run_until_done(20, n, g0, g1, ge, rd);
        check("t4_commence_cycles", n, 4);
        check("t4_done1", g1, 1'b1);
        check("t4_err", ge, 1'b0);
        req1 = 1'b0; req1_indirect = 1'b0;
        @(negedge clk);

        // 5a: read timeout after 256 wait cycles
        req1 = 1'b1; req1_op = 2'b10; req1_addr = 16'h0100; cache_rdata = 16'h9999;
        run_until_done(300, n, g0, g1, ge, rd);
        check("t5a_commence_cycles", n, 257);
        check("t5a_done1", g1, 1'b1);
        check("t5a_err", ge, 1'b1);
        check("t5a_rdata_unchanged", rd, 16'h5A5A);
        req1 = 1'b0;
        @(negedge clk);

        // 5b: ready arriving on the timeout cycle wins
        req1 = 1'b1; req1_indirect = 1'b1; cache_rdata = 16'h7777;
        n = 0; g1 = 1'b0; ge = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done0 || done1) begin
                g1 = done1; ge = err; rd = rdata;
                break;
            end
            if (commence) begin
                n++;
                if (n == 1) check("t5b_indirect", indirect, 1'b1);
                if (n == 257) cache_ready = 1'b1;
            end
        end
        check("t5b_commence_cycles", n, 257);
        check("t5b_done1", g1, 1'b1);
        check("t5b_err", ge, 1'b0);
        check("t5b_rdata", rd, 16'h7777);
        req1 = 1'b0; req1_indirect = 1'b0; cache_ready = 1'b0;
        @(negedge clk);

        // 6: illegal op answers at once, controller untouched
        req1 = 1'b1; req1_op = 2'b01; req1_addr = 16'h0444;
        run_until_done(10, n, g0, g1, ge, rd);
        check("t6_commence_never", n, 0);
        check("t6_done1", g1, 1'b1);
        check("t6_err", ge, 1'b1);
        check("t6_ctrl", ctrl, 2'b01);
        req1 = 1'b0;
        @(negedge clk);

        // 7: after a port 0 grant, a tie goes to port 1
        req0 = 1'b1; req0_addr = 16'h0200; cache_ready = 1'b1; cache_rdata = 16'h0A0A;
        run_until_done(10, n, g0, g1, ge, rd);
        check("t7_solo_port0", g0, 1'b1);
        req0 = 1'b0;
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; req1_op = 2'b10; req1_addr = 16'h0300;
        cache_rdata = 16'h0B0B;
        run_until_done(10, n, g0, g1, ge, rd);
        check("t7_tie_port1_first", {g1, g0}, 2'b10);
        check("t7_rdata1", rd, 16'h0B0B);
        req1 = 1'b0;
        run_until_done(10, n, g0, g1, ge, rd);
        check("t7_then_port0", g0, 1'b1);
        req0 = 1'b0; cache_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
